// File: rtl/coin_pkg.sv
// Shared coin-code constants and transmitter state encoding.
package coin_pkg;
  localparam logic [1:0] CODE_IDLE   = 2'b00;
  localparam logic [1:0] CODE_NICKEL = 2'b01;
  localparam logic [1:0] CODE_DIME   = 2'b11;

  typedef enum logic [1:0] {IDLE, SEND, GAP, CANCEL} state_e;
endpackage

// File: rtl/coin_fifo.sv
// Pending-coin queue: two ordered write ports, one pop, synchronous flush.
// Pointers carry one extra wrap bit so a full queue is distinguishable from empty.
module coin_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          pop_i,
  input  logic          wr0_en_i,
  input  logic [1:0]    wr0_dat_i,
  input  logic          wr1_en_i,
  input  logic [1:0]    wr1_dat_i,
  output logic [1:0]    rd_dat_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [1:0]    mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [AW-1:0] widx0, widx1;

  always_comb begin
    widx0  = wptr_q[AW-1:0];
    widx1  = widx0 + AW'(wr0_en_i);
    wptr_d = wptr_q + (AW+1)'(wr0_en_i) + (AW+1)'(wr1_en_i);
    rptr_d = rptr_q + (AW+1)'(pop_i);
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      if (wr0_en_i) mem_q[widx0] <= wr0_dat_i;
      if (wr1_en_i) mem_q[widx1] <= wr1_dat_i;
    end
  end

  assign rd_dat_o = mem_q[rptr_q[AW-1:0]];
  assign count_o  = wptr_q - rptr_q;
  assign full_o   = (count_o == (AW+1)'(DEPTH));
  assign empty_o  = (count_o == '0);
endmodule

// File: rtl/coin_tx.sv
// Coin-event transmitter: edge-detects sensors, queues coin codes and paces them
// onto {x1,x0} as one code cycle plus GAP_CYCLES idle cycles; cancel flushes and pulses vm_r.
module coin_tx
  import coin_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       r,
  input  logic       nickel_in,
  input  logic       dime_in,
  input  logic       cancel_in,
  output logic       x1,
  output logic       x0,
  output logic       vm_r,
  output logic       full,
  output logic       empty,
  output logic [3:0] drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  logic          nick_q, dime_q, canc_q;
  logic          nick_ev, dime_ev, canc_ev;
  state_e        state_q;
  logic [GW-1:0] gap_q;
  logic [1:0]    x_q;
  logic          vm_r_q;
  logic [3:0]    drop_q, drop_d;
  logic [AW:0]   count;
  logic [1:0]    head;
  logic          f_empty;
  logic          pop, gap_end;
  logic [AW+1:0] space;
  logic [1:0]    n_ev, n_acc;
  logic          wr0_en, wr1_en;
  logic [1:0]    wr0_dat;
  logic [4:0]    drop_sum;

  assign nick_ev = nickel_in & ~nick_q;
  assign dime_ev = dime_in & ~dime_q;
  assign canc_ev = cancel_in & ~canc_q;

  always_comb begin
    gap_end = (gap_q == GW'(GAP_CYCLES - 1));
    pop     = 1'b0;
    if (!canc_ev && !f_empty)
      pop = (state_q == IDLE) || ((state_q == GAP) && gap_end);
    // Space counts this cycle's pop so a full queue can pop and push together.
    space    = (AW+2)'(DEPTH) - (AW+2)'(count) + (AW+2)'(pop);
    wr0_dat  = dime_ev ? CODE_DIME : CODE_NICKEL;
    n_ev     = canc_ev ? 2'd0 : (2'(nick_ev) + 2'(dime_ev));
    wr0_en   = (n_ev != 2'd0) && (space != '0);
    wr1_en   = (n_ev == 2'd2) && (space >= (AW+2)'(2));
    n_acc    = 2'(wr0_en) + 2'(wr1_en);
    drop_sum = {1'b0, drop_q} + 5'(n_ev - n_acc);
    drop_d   = (drop_sum > 5'd15) ? 4'hF : drop_sum[3:0];
  end

  coin_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i     (clk),
    .rst_i     (r),
    .flush_i   (canc_ev),
    .pop_i     (pop),
    .wr0_en_i  (wr0_en),
    .wr0_dat_i (wr0_dat),
    .wr1_en_i  (wr1_en),
    .wr1_dat_i (CODE_NICKEL),
    .rd_dat_o  (head),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (f_empty)
  );

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      nick_q  <= 1'b0;
      dime_q  <= 1'b0;
      canc_q  <= 1'b0;
      state_q <= IDLE;
      gap_q   <= '0;
      x_q     <= CODE_IDLE;
      vm_r_q  <= 1'b0;
      drop_q  <= 4'd0;
    end else begin
      nick_q <= nickel_in;
      dime_q <= dime_in;
      canc_q <= cancel_in;
      drop_q <= drop_d;
      vm_r_q <= 1'b0;
      if (canc_ev) begin
        state_q <= CANCEL;
        x_q     <= CODE_IDLE;
        vm_r_q  <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (pop) begin
              x_q     <= head;
              state_q <= SEND;
            end else begin
              x_q <= CODE_IDLE;
            end
          end
          SEND: begin
            x_q     <= CODE_IDLE;
            gap_q   <= '0;
            state_q <= GAP;
          end
          GAP: begin
            if (!gap_end) begin
              gap_q <= gap_q + GW'(1);
            end else if (pop) begin
              x_q     <= head;
              state_q <= SEND;
            end else begin
              state_q <= IDLE;
            end
          end
          default: begin
            x_q     <= CODE_IDLE;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign x1       = x_q[1];
  assign x0       = x_q[0];
  assign vm_r     = vm_r_q;
  assign empty    = f_empty;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_coin_tx.sv
// Directed bench for coin_tx; a queue scoreboard holds the codes expected on {x1,x0}.
module tb_coin_tx;
  logic       clk = 1'b0;
  logic       r, nickel, dime, cancel, zero_s;
  logic       x1, x0, vm_r, full, empty;
  logic [3:0] drop;
  logic       xs1, xs0, vms, fulls, emptys;
  logic [3:0] drops;
  logic [1:0] sb [$];
  logic [1:0] prev_code, cur_code, exp_code;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  coin_tx #(.DEPTH(4), .GAP_CYCLES(1)) dut (
    .clk(clk), .r(r), .nickel_in(nickel), .dime_in(dime), .cancel_in(cancel),
    .x1(x1), .x0(x0), .vm_r(vm_r), .full(full), .empty(empty), .drop_cnt(drop)
  );

  // Long gap so a nickel toggling every other cycle outruns the drain and saturates drops.
  coin_tx #(.DEPTH(4), .GAP_CYCLES(7)) u_sat (
    .clk(clk), .r(r), .nickel_in(nickel), .dime_in(zero_s), .cancel_in(zero_s),
    .x1(xs1), .x0(xs0), .vm_r(vms), .full(fulls), .empty(emptys), .drop_cnt(drops)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (r) begin
      prev_code = 2'b00;
    end else begin
      cur_code = {x1, x0};
      if (cur_code != 2'b00) begin
        check("code_gap", 8'(prev_code), 8'h0);
        if (sb.size() == 0) begin
          check("unexpected_code", 8'(cur_code), 8'h0);
        end else begin
          exp_code = sb.pop_front();
          check("code", 8'(cur_code), 8'(exp_code));
        end
      end
      prev_code = cur_code;
      if ({xs1, xs0} != 2'b00) check("sat_code", 8'({xs1, xs0}), 8'h01);
    end
  end

  initial begin
    r = 1'b1; nickel = 1'b0; dime = 1'b0; cancel = 1'b0; zero_s = 1'b0;
    repeat (2) tick();
    check("rst_x", 8'({x1, x0}), 8'h0);
    check("rst_vm_r", 8'(vm_r), 8'h0);
    check("rst_full", 8'(full), 8'h0);
    check("rst_empty", 8'(empty), 8'h1);
    check("rst_drop", 8'(drop), 8'h0);
    r = 1'b0;

    // Single held dime
    tick();
    dime = 1'b1; sb.push_back(2'b11);
    tick();
    check("single_enq", 8'(empty), 8'h0);
    repeat (4) tick();
    dime = 1'b0;
    repeat (4) tick();
    check("single_drop", 8'(drop), 8'h0);
    check("single_empty", 8'(empty), 8'h1);
    check("single_drain", 8'(sb.size()), 8'h0);

    // Simultaneous nickel + dime: dime goes first
    nickel = 1'b1; dime = 1'b1;
    sb.push_back(2'b11); sb.push_back(2'b01);
    tick();
    nickel = 1'b0; dime = 1'b0;
    repeat (6) tick();
    check("simul_drain", 8'(sb.size()), 8'h0);

    // Overflow: four simultaneous pairs, last nickel dropped
    for (int k = 0; k < 4; k++) begin
      nickel = 1'b1; dime = 1'b1;
      sb.push_back(2'b11);
      if (k < 3) sb.push_back(2'b01);
      tick();
      if (k == 3) begin
        check("ovf_drop", 8'(drop), 8'h1);
        check("ovf_full", 8'(full), 8'h1);
      end
      nickel = 1'b0; dime = 1'b0;
      tick();
    end
    repeat (12) tick();
    check("ovf_empty", 8'(empty), 8'h1);
    check("ovf_drop_hold", 8'(drop), 8'h1);
    check("ovf_drain", 8'(sb.size()), 8'h0);

    // Cancel during the first SEND, with a second nickel arriving on the cancel edge
    nickel = 1'b1; sb.push_back(2'b01);
    tick();
    nickel = 1'b0;
    tick();
    check("cxl_send", 8'({x1, x0}), 8'h01);
    cancel = 1'b1; nickel = 1'b1;
    tick();
    check("cxl_x", 8'({x1, x0}), 8'h0);
    check("cxl_vm_r", 8'(vm_r), 8'h1);
    check("cxl_empty", 8'(empty), 8'h1);
    nickel = 1'b0;
    tick();
    check("cxl_vm_r_end", 8'(vm_r), 8'h0);
    cancel = 1'b0;
    repeat (8) tick();
    check("cxl_drop", 8'(drop), 8'h1);
    check("cxl_empty_hold", 8'(empty), 8'h1);
    check("cxl_drain", 8'(sb.size()), 8'h0);

    // Async reset mid-GAP with two entries queued
    nickel = 1'b1; dime = 1'b1; sb.push_back(2'b11);
    tick();
    nickel = 1'b0; dime = 1'b0;
    tick();
    nickel = 1'b1;
    tick();
    check("gap_queued", 8'(empty), 8'h0);
    #2 r = 1'b1;
    #1;
    check("arst_x", 8'({x1, x0}), 8'h0);
    check("arst_vm_r", 8'(vm_r), 8'h0);
    check("arst_full", 8'(full), 8'h0);
    check("arst_empty", 8'(empty), 8'h1);
    check("arst_drop", 8'(drop), 8'h0);
    nickel = 1'b0;
    tick();
    r = 1'b0;
    repeat (10) tick();
    check("arst_idle_empty", 8'(empty), 8'h1);
    check("arst_drain", 8'(sb.size()), 8'h0);

    // Nickel toggling every cycle: main keeps pace, long-gap instance saturates
    for (int i = 0; i < 80; i++) begin
      nickel = (i % 2 == 0);
      if (nickel) sb.push_back(2'b01);
      tick();
      if (i == 59) begin
        check("sat_drop_15", 8'(drops), 8'hF);
        check("sat_full", 8'(fulls), 8'h1);
        check("pace_drop", 8'(drop), 8'h0);
      end
    end
    check("sat_drop_hold", 8'(drops), 8'hF);
    nickel = 1'b0;
    repeat (8) tick();
    check("pace_drop_end", 8'(drop), 8'h0);
    check("pace_drain", 8'(sb.size()), 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/coin_tx.md
# coin_tx

Coin-event transmitter for the vending-machine controller. It turns raw nickel/dime sensor levels and a cancel button into the one-cycle coin codes and the reset pulse that the controller samples. Coin events are held in a small FIFO, and each one is sent as a single `x1`/`x0` code cycle followed by idle gap cycles. It sits between the coin-slot sensors and the controller's `x1`, `x0` and `r` inputs.

## Interface
Parameters:
- `DEPTH`, default 4: pending-coin FIFO entries; must be a power of 2, at least 2.
- `GAP_CYCLES`, default 1: idle `00` cycles forced after every coin code; must be at least 1.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `r`, in, 1: reset, asynchronous and active-high.
- `nickel_in`, in, 1: nickel sensor level, already synchronous to `clk`.
- `dime_in`, in, 1: dime sensor level, already synchronous to `clk`.
- `cancel_in`, in, 1: cancel button level, already synchronous to `clk`.
- `x1`, out, 1: coin code MSB to the controller (registered).
- `x0`, out, 1: coin code LSB to the controller (registered).
- `vm_r`, out, 1: reset pulse to the controller (registered).
- `full`, out, 1: FIFO occupancy equals `DEPTH`.
- `empty`, out, 1: FIFO occupancy equals 0.
- `drop_cnt`, out, 4: saturating count of coin events lost to a full FIFO.

## Operation
- Codes on `{x1,x0}`:
  - 00: idle.
  - 01: nickel.
  - 11: dime.
  - 10: reserved; never driven.
- Edge detection: one registered copy of each input.
  - An event is a sample of 1 where the previous sample was 0.
  - A held level produces exactly one event.
- Enqueue:
  - Each event is written to the FIFO at the edge where it is detected.
  - If nickel and dime edges occur in the same cycle, the dime is written first, then the nickel.
  - Space is computed after this cycle's pop, so pop-then-push in one cycle is legal.
  - An event that finds no space is discarded and increments `drop_cnt`, which saturates at 15.
  - If both events are dropped in one cycle, `drop_cnt` increases by 2, still saturating.
- State machine:
  - IDLE: `x`=00. If the FIFO is non-empty, pop the head, load its code into `x`, and go to SEND.
  - SEND: lasts one cycle with `x` = the code. Then go to GAP.
  - GAP: lasts `GAP_CYCLES` cycles with `x`=00. At the end of the last gap cycle, pop and go to SEND if non-empty, else go to IDLE.
  - CANCEL: lasts one cycle with `vm_r`=1 and `x`=00. Then go to IDLE.
- Cancel: a `cancel_in` rising edge, from any state, does the following at that edge:
  - flushes the FIFO;
  - discards nickel/dime events detected in the same cycle (these are not counted as drops);
  - enters CANCEL.
  - An in-flight SEND is truncated: `x` becomes 00 from the next cycle.
  - `drop_cnt` is unchanged.
- Reset: the asynchronous assertion of `r` sets:
  - `x1`=0, `x0`=0, `vm_r`=0;
  - `full`=0, `empty`=1, `drop_cnt`=0;
  - state IDLE and FIFO pointers 0;
  - edge-detect registers 0, so a level already high at release produces an event on the first sampling edge.
  - Reset mid-SEND drops the code immediately.

## Timing
- Sensor edge sampled at edge t → enqueued at edge t → code on `x` during the cycle after edge t+1 (when the FIFO was empty and state IDLE).
- Sustained throughput: one code per `1+GAP_CYCLES` cycles. Back-to-back codes are never adjacent.
- `full`/`empty` reflect occupancy after the current edge; they are not registered separately.
- `vm_r` is exactly one cycle wide, one cycle after the cancel edge.

## Structure
- Package `coin_pkg`:
  - code constants `CODE_IDLE`=2'b00, `CODE_NICKEL`=2'b01, `CODE_DIME`=2'b11;
  - the state enum IDLE/SEND/GAP/CANCEL.
- One sub-module `coin_fifo`: DEPTH×2-bit storage.
  - Two write ports (ordered), one pop, and a synchronous flush.
  - Outputs occupancy count, `full` and `empty`.
- The top level holds the edge detectors, the FSM, the output registers and `drop_cnt`.

## Test plan
All scenarios use `DEPTH`=4 and `GAP_CYCLES`=1 unless stated otherwise.
- Single event: assert `r`, release, then raise `dime_in` and hold it 5 cycles → `x`=11 for exactly one cycle, then 00 throughout. `drop_cnt`=0.
- Simultaneous: nickel and dime rise on the same edge → `x` sequence 11, 00, 01, 00.
- Overflow: simultaneous nickel+dime edges at edges 0, 2, 4, 6 (inputs toggled each cycle) → at edge 6 the dime is accepted and the nickel dropped. Result: `drop_cnt`=1, `full`=1. Output codes 11, 01, 11, 01, 11, 01, 11 follow, each separated by 00.
- Cancel mid-stream: queue 3 nickels, then raise `cancel_in` during the first SEND.
  - `x`=00 next cycle; `vm_r`=1 for one cycle; `empty`=1.
  - No further codes; `drop_cnt` unchanged.
- Async reset mid-GAP with 2 entries queued: assert `r` between clock edges.
  - All outputs return immediately to their reset values.
  - After release, `x` stays 00 with no stale codes.
- Saturation: with `dime_in` held 0, toggle `nickel_in` every cycle for 60 cycles → `drop_cnt` reaches 15 and holds. `x` only ever shows 01 or 00.
